sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Pixel-pipeline stage directly upstream of the colour palette lookup.
- Per pixel, selects between one animated, ROM-backed sprite and a background colour index.
- Emits the 16-bit palette index consumed by the palette, with a delayed DrawX/DrawY aligned to it.
- Sprite position, enable and animation are latched once per frame, so the sprite does not tear mid-scan.

Parameters:
- SPR_W, 32: sprite width in pixels; power of two.
- SPR_H, 32: sprite height in pixels; power of two.
- NUM_FRAMES, 4: animation frames stored in ROM; power of two.
- FRAME_HOLD, 8: vsync pulses per animation frame; must be at least 1.
- TRANSPARENT, 12: palette index treated as see-through.
- ROM_AW, 12: ROM address width; must be at least log2(SPR_W*SPR_H*NUM_FRAMES).

Ports:
- Clk, input, 1: pixel clock.
- Reset_n, input, 1: asynchronous, active-low reset.
- frame_start, input, 1: one-cycle pulse at start of vertical blank.
- DrawX, input, 10: current pixel column.
- DrawY, input, 10: current pixel row.
- blank_n, input, 1: high while the pixel is in the visible area.
- bg_color, input, 16: background palette index for this pixel.
- sprite_x, input, 10: requested sprite left edge, sampled only at frame_start.
- sprite_y, input, 10: requested sprite top edge, sampled only at frame_start.
- sprite_en, input, 1: requested sprite visibility, sampled only at frame_start.
- anim_en, input, 1: animation advance enable, sampled only at frame_start.
- mirror, input, 1: horizontal flip request, sampled at frame_start (used only with SPRITE_MIRROR_EN).
- rom_addr, output, ROM_AW: sprite ROM read address.
- rom_data, input, 8: ROM read data; synchronous ROM, valid exactly 1 cycle after rom_addr.
- color, output, 16: palette index for the palette stage.
- DrawX_out, output, 10: DrawX delayed to align with color.
- DrawY_out, output, 10: DrawY delayed to align with color.
- blank_n_out, output, 1: blank_n delayed to align with color.

Behaviour:
- Reset (async assert, sync release):
  - color = 0, DrawX_out = 0, DrawY_out = 0, blank_n_out = 0, rom_addr = 0.
  - Latched sx = 0, sy = 0, spr_on = 0, mir = 0.
  - Animation frame index fi = 0, hold counter hc = 0.
- Frame latch:
  - On a cycle with frame_start = 1, register sprite_x, sprite_y, sprite_en and mirror into sx, sy, spr_on, mir.
  - Changes to these inputs at any other time have no effect.
- Animation counter, evaluated on frame_start:
  - anim_en = 1 and hc = FRAME_HOLD-1: hc <= 0; fi <= fi+1, wrapping NUM_FRAMES-1 -> 0.
  - anim_en = 1 otherwise: hc <= hc+1.
  - anim_en = 0: hc and fi hold.
- Stage 0 (cycle n):
  - dx = {1'b0,DrawX} - {1'b0,sx} and dy = {1'b0,DrawY} - {1'b0,sy}, both 11-bit.
  - hit0 = spr_on & blank_n & (dx < SPR_W) & (dy < SPR_H), unsigned compare.
  - A pixel left of or above the sprite gives a large dx/dy, so it is not a hit; there is no wrap-around.
  - rom_addr <= {fi, dy[log2 SPR_H-1:0], dx[log2 SPR_W-1:0]}, zero-extended to ROM_AW.
  - Register hit0, bg_color, DrawX, DrawY and blank_n into stage 1.
- Stage 1 (cycle n+1):
  - rom_data is valid.
  - If hit1 and rom_data != TRANSPARENT: color <= {8'h00, rom_data}.
  - Else if blank_n1 = 0: color <= 0.
  - Else: color <= bg1.
  - DrawX_out, DrawY_out, blank_n_out <= stage-1 copies.
- Latency: exactly 2 cycles from DrawX/DrawY/blank_n/bg_color to color and the aligned outputs.
  - Pipeline is fully streaming, one pixel per clock, no stalls.
- Simultaneous events:
  - frame_start during a visible pixel: the new sx/sy apply from the next cycle's stage 0.
  - A fi advance coinciding with a pixel read takes effect on the next pixel.
- Sprite partially past column 639 or row 479: clipped naturally, because off-screen coordinates are never driven.
- Reset mid-frame: outputs return to reset values immediately; the sprite is hidden until the first frame_start after release.

Optional Feature:
- Macro: SPRITE_MIRROR_EN.
- Defined, and mir = 1: the column field of rom_addr is (SPR_W-1) - dx[log2 SPR_W-1:0], giving a horizontally flipped sprite.
- Defined, and mir = 0: unflipped.
- Not defined: the mirror input is ignored, mir does not exist, and addressing always uses dx directly.

Test Plan:
- Reset with Reset_n = 0 mid-stream -> color = 0, blank_n_out = 0 and rom_addr = 0 in the same cycle.
  - After release and before any frame_start, pixels show bg_color only.
- frame_start with sprite_x = 100, sprite_y = 50, sprite_en = 1; then DrawX = 100, DrawY = 50, ROM model returns 8'd24 -> 2 cycles later color = 16'd24, DrawX_out = 100, DrawY_out = 50, and rom_addr = 0 on the cycle after input.
- Same setup, ROM returns 12 (TRANSPARENT), bg_color = 35 -> color = 35.
- Edge pixels:
  - DrawX = 99 -> bg; DrawX = 131 -> sprite; DrawX = 132 -> bg.
  - DrawY = 81 -> sprite; DrawY = 82 -> bg.
  - blank_n = 0 -> color = 0.
- anim_en = 1, FRAME_HOLD = 8:
  - fi increments after the 8th, 16th, 24th and 32nd frame_start.
  - fi wraps 3 -> 0 at the 32nd.
  - rom_addr top bits track fi.
  - anim_en = 0 freezes fi and hc.
- SPRITE_MIRROR_EN defined, mirror = 1 latched, DrawX = sx -> rom_addr column field = 31.
  - Without the macro -> 0.
  - Changing sprite_x mid-frame without frame_start -> no change in hit region.

Source files
------------

// File: rtl/sprite_compositor.sv
// Two-stage sprite/background compositor feeding the palette lookup; sprite state latched per frame.
// Optional horizontal flip is compiled in with SPRITE_MIRROR_EN.
module sprite_compositor #(
  parameter int SPR_W       = 32,
  parameter int SPR_H       = 32,
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_HOLD  = 8,
  parameter int TRANSPARENT = 12,
  parameter int ROM_AW      = 12
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank_n,
  input  logic [15:0]       bg_color,
  input  logic [9:0]        sprite_x,
  input  logic [9:0]        sprite_y,
  input  logic              sprite_en,
  input  logic              anim_en,
  input  logic              mirror,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [15:0]       color,
  output logic [9:0]        DrawX_out,
  output logic [9:0]        DrawY_out,
  output logic              blank_n_out
);
  localparam int CW = $clog2(SPR_W);
  localparam int RW = $clog2(SPR_H);
  localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int HW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  logic [9:0]        r_sx, r_sy;
  logic              r_spr_on;
  logic [FW-1:0]     r_fi;
  logic [HW-1:0]     r_hc;
  logic [ROM_AW-1:0] r_rom_addr;
  logic              r_hit1, r_blank1, r_blank2;
  logic [15:0]       r_bg1, r_color;
  logic [9:0]        r_x1, r_y1, r_x2, r_y2;

  logic [10:0]       w_dx, w_dy;
  logic              w_hit0;
  logic [CW-1:0]     w_col;
  logic [15:0]       w_color;

  // Sprite placement only changes at frame_start so a frame never shows two positions.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sx     <= '0;
      r_sy     <= '0;
      r_spr_on <= 1'b0;
    end else if (frame_start) begin
      r_sx     <= sprite_x;
      r_sy     <= sprite_y;
      r_spr_on <= sprite_en;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_hc <= '0;
      r_fi <= '0;
    end else if (frame_start && anim_en) begin
      if (r_hc == HW'(FRAME_HOLD - 1)) begin
        r_hc <= '0;
        r_fi <= (r_fi == FW'(NUM_FRAMES - 1)) ? '0 : r_fi + 1'b1;
      end else begin
        r_hc <= r_hc + 1'b1;
      end
    end
  end

`ifdef SPRITE_MIRROR_EN
  logic r_mir;
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)         r_mir <= 1'b0;
    else if (frame_start) r_mir <= mirror;
  end
  assign w_col = r_mir ? (CW'(SPR_W - 1) - w_dx[CW-1:0]) : w_dx[CW-1:0];
`else
  logic w_unused_mirror;
  assign w_unused_mirror = mirror;
  assign w_col = w_dx[CW-1:0];
`endif

  // 11-bit unsigned difference: pixels left of/above the sprite become huge and miss.
  assign w_dx   = {1'b0, DrawX} - {1'b0, r_sx};
  assign w_dy   = {1'b0, DrawY} - {1'b0, r_sy};
  assign w_hit0 = r_spr_on & blank_n & (w_dx < 11'(SPR_W)) & (w_dy < 11'(SPR_H));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_rom_addr <= '0;
      r_hit1     <= 1'b0;
      r_bg1      <= '0;
      r_x1       <= '0;
      r_y1       <= '0;
      r_blank1   <= 1'b0;
    end else begin
      r_rom_addr <= ROM_AW'({r_fi, w_dy[RW-1:0], w_col});
      r_hit1     <= w_hit0;
      r_bg1      <= bg_color;
      r_x1       <= DrawX;
      r_y1       <= DrawY;
      r_blank1   <= blank_n;
    end
  end

  always_comb begin
    w_color = r_bg1;
    if (r_hit1 && (rom_data != 8'(TRANSPARENT))) w_color = {8'h00, rom_data};
    else if (!r_blank1)                          w_color = '0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_color  <= '0;
      r_x2     <= '0;
      r_y2     <= '0;
      r_blank2 <= 1'b0;
    end else begin
      r_color  <= w_color;
      r_x2     <= r_x1;
      r_y2     <= r_y1;
      r_blank2 <= r_blank1;
    end
  end

  assign rom_addr    = r_rom_addr;
  assign color       = r_color;
  assign DrawX_out   = r_x2;
  assign DrawY_out   = r_y2;
  assign blank_n_out = r_blank2;
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a sync-ROM model (data follows registered rom_addr).
module tb_sprite_compositor;
  logic        Clk = 1'b0, Reset_n = 1'b0, frame_start = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0, sprite_x = '0, sprite_y = '0;
  logic        blank_n = 1'b0, sprite_en = 1'b0, anim_en = 1'b0, mirror = 1'b0;
  logic [15:0] bg_color = '0;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data;
  logic [15:0] color;
  logic [9:0]  DrawX_out, DrawY_out;
  logic        blank_n_out;
  logic [7:0]  rom [0:4095];
  int n_pass = 0, n_chk = 0;

  sprite_compositor dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .DrawX(DrawX), .DrawY(DrawY),
    .blank_n(blank_n), .bg_color(bg_color), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .sprite_en(sprite_en), .anim_en(anim_en), .mirror(mirror), .rom_addr(rom_addr),
    .rom_data(rom_data), .color(color), .DrawX_out(DrawX_out), .DrawY_out(DrawY_out),
    .blank_n_out(blank_n_out));

  assign rom_data = rom[rom_addr];
  always #5 Clk = ~Clk;

  task automatic tick; @(posedge Clk); #1; endtask

  task automatic frame(input [9:0] x, input [9:0] y, input en, input an, input mr);
    sprite_x = x; sprite_y = y; sprite_en = en; anim_en = an; mirror = mr;
    frame_start = 1'b1; tick; frame_start = 1'b0;
  endtask

  // One isolated pixel: address seen after the first edge, colour and aligned outputs after the second.
  task automatic run_pix(input [9:0] x, input [9:0] y, input b, input [15:0] bg,
                         output [11:0] a, output [15:0] c, output [9:0] xo, output [9:0] yo, output bo);
    DrawX = x; DrawY = y; blank_n = b; bg_color = bg; tick;
    a = rom_addr;
    DrawX = '0; DrawY = '0; blank_n = 1'b0; bg_color = '0; tick;
    c = color; xo = DrawX_out; yo = DrawY_out; bo = blank_n_out;
  endtask

  logic [11:0] a; logic [15:0] c; logic [9:0] xo, yo; logic bo;

  task automatic test_reset;
    Reset_n = 1'b0; tick; tick;
    n_chk++; if (color !== 16'd0) $display("FAIL reset_color got %0d exp 0", color); else n_pass++;
    n_chk++; if (blank_n_out !== 1'b0) $display("FAIL reset_blank got %b exp 0", blank_n_out); else n_pass++;
    n_chk++; if (rom_addr !== 12'd0) $display("FAIL reset_addr got %0d exp 0", rom_addr); else n_pass++;
    n_chk++; if (DrawX_out !== 10'd0) $display("FAIL reset_x got %0d exp 0", DrawX_out); else n_pass++;
    Reset_n = 1'b1; tick;
    sprite_x = 10'd100; sprite_y = 10'd50; sprite_en = 1'b1;
    run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (c !== 16'd35) $display("FAIL no_frame_bg got %0d exp 35", c); else n_pass++;
  endtask

  task automatic test_hit;
    rom[0] = 8'd24;
    frame(10'd100, 10'd50, 1'b1, 1'b0, 1'b0);
    run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (a !== 12'd0) $display("FAIL hit_addr got %0d exp 0", a); else n_pass++;
    n_chk++; if (c !== 16'd24) $display("FAIL hit_color got %0d exp 24", c); else n_pass++;
    n_chk++; if (xo !== 10'd100) $display("FAIL hit_xout got %0d exp 100", xo); else n_pass++;
    n_chk++; if (yo !== 10'd50) $display("FAIL hit_yout got %0d exp 50", yo); else n_pass++;
    n_chk++; if (bo !== 1'b1) $display("FAIL hit_blank got %b exp 1", bo); else n_pass++;
  endtask

  task automatic test_transparent;
    rom[0] = 8'd12;
    run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (c !== 16'd35) $display("FAIL transparent got %0d exp 35", c); else n_pass++;
    rom[0] = 8'd24;
  endtask

  task automatic test_edges;
    logic [9:0]  ex [7] = '{10'd99, 10'd131, 10'd132, 10'd100, 10'd100, 10'd100, 10'd100};
    logic [9:0]  ey [7] = '{10'd50, 10'd50,  10'd50,  10'd81,  10'd82,  10'd50,  10'd49};
    logic        eb [7] = '{1'b1,   1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b1};
    logic [15:0] ec [7] = '{16'd35, 16'd200, 16'd35,  16'd200, 16'd35,  16'd0,   16'd35};
    for (int i = 0; i < 7; i++) begin
      run_pix(ex[i], ey[i], eb[i], 16'd35, a, c, xo, yo, bo);
      n_chk++;
      if (c !== ec[i]) $display("FAIL edge%0d (%0d,%0d) got %0d exp %0d", i, ex[i], ey[i], c, ec[i]);
      else n_pass++;
    end
    run_pix(10'd131, 10'd81, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (a !== 12'd1023) $display("FAIL corner_addr got %0d exp 1023", a); else n_pass++;
  endtask

  task automatic test_latch;
    sprite_x = 10'd300;
    run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (c !== 16'd24) $display("FAIL latch_old got %0d exp 24", c); else n_pass++;
    run_pix(10'd300, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (c !== 16'd35) $display("FAIL latch_new_early got %0d exp 35", c); else n_pass++;
    frame(10'd300, 10'd50, 1'b1, 1'b0, 1'b0);
    run_pix(10'd300, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (c !== 16'd24) $display("FAIL latch_applied got %0d exp 24", c); else n_pass++;
    frame(10'd100, 10'd50, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_mirror;
    logic [11:0] exp_a; logic [15:0] exp_c;
`ifdef SPRITE_MIRROR_EN
    exp_a = 12'd31; exp_c = 16'd200;
`else
    exp_a = 12'd0;  exp_c = 16'd24;
`endif
    frame(10'd100, 10'd50, 1'b1, 1'b0, 1'b1);
    run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (a !== exp_a) $display("FAIL mirror_addr got %0d exp %0d", a, exp_a); else n_pass++;
    n_chk++; if (c !== exp_c) $display("FAIL mirror_color got %0d exp %0d", c, exp_c); else n_pass++;
    frame(10'd100, 10'd50, 1'b1, 1'b0, 1'b0);
    run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (a !== 12'd0) $display("FAIL unmirror_addr got %0d exp 0", a); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp_c [4] = '{16'd35, 16'd24, 16'd77, 16'd78};
    rom[1] = 8'd77; rom[2] = 8'd78;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin DrawX = 10'(99 + k); DrawY = 10'd50; blank_n = 1'b1; bg_color = 16'd35; end
      else begin DrawX = '0; DrawY = '0; blank_n = 1'b0; bg_color = '0; end
      tick;
      if (k >= 1 && k <= 4) begin
        n_chk++;
        if (color !== exp_c[k-1] || DrawX_out !== 10'(98 + k))
          $display("FAIL stream%0d color %0d x %0d exp %0d x %0d", k-1, color, DrawX_out, exp_c[k-1], 98 + k);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_midstream;
    DrawX = 10'd100; DrawY = 10'd50; blank_n = 1'b1; bg_color = 16'd35; tick; tick;
    n_chk++; if (color !== 16'd24) $display("FAIL pre_reset got %0d exp 24", color); else n_pass++;
    Reset_n = 1'b0; #1;
    n_chk++; if (color !== 16'd0 || blank_n_out !== 1'b0 || rom_addr !== 12'd0)
      $display("FAIL midreset color %0d blank %b addr %0d exp 0 0 0", color, blank_n_out, rom_addr);
    else n_pass++;
    blank_n = 1'b0; tick; Reset_n = 1'b1; tick;
    run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (c !== 16'd35) $display("FAIL post_reset_hidden got %0d exp 35", c); else n_pass++;
  endtask

  task automatic test_anim;
    logic [11:0] exp_a;
    for (int n = 1; n <= 32; n++) begin
      frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b0);
      run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
      exp_a = 12'(((n / 8) % 4) << 10);
      n_chk++; if (a !== exp_a) $display("FAIL anim_n%0d addr got %0d exp %0d", n, a, exp_a); else n_pass++;
    end
    for (int n = 0; n < 8; n++) frame(10'd100, 10'd50, 1'b1, 1'b0, 1'b0);
    run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (a !== 12'd0) $display("FAIL anim_frozen got %0d exp 0", a); else n_pass++;
    for (int n = 0; n < 7; n++) frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b0);
    run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (a !== 12'd0) $display("FAIL anim_hc_held7 got %0d exp 0", a); else n_pass++;
    frame(10'd100, 10'd50, 1'b1, 1'b1, 1'b0);
    run_pix(10'd100, 10'd50, 1'b1, 16'd35, a, c, xo, yo, bo);
    n_chk++; if (a !== 12'd1024) $display("FAIL anim_hc_held8 got %0d exp 1024", a); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'd200;
    test_reset;
    test_hit;
    test_transparent;
    test_edges;
    test_latch;
    test_mirror;
    test_back_to_back;
    test_reset_midstream;
    test_anim;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
